// File: rtl/line_renderer.sv
// line_renderer: expands packed pixel commands into line-buffer writes (palette, flip, sprite transparency, priority).
// Latency: pixel 0 slot is registered on the outputs the cycle after accept, then one slot per cycle, no gaps.
// Backpressure: one active plus one pending command; cmd_ready is low while pending is full.
// Optional feature: define LINE_RENDERER_HDOUBLE_EN to build horizontal pixel doubling (cmd_double).
module line_renderer #(
  parameter int IDX_W = 9,
  parameter int PAL_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [IDX_W-1:0] cmd_idx,
  input  logic [31:0]      cmd_data,
  input  logic [1:0]       cmd_bpp,
  input  logic [PAL_W-1:0] cmd_palette,
  input  logic             cmd_sprite,
  input  logic             cmd_hflip,
  input  logic             cmd_priority,
  input  logic             cmd_double,
  output logic             busy,
  output logic             last_pixel,
  output logic [IDX_W-1:0] wridx,
  output logic [7:0]       wrdata,
  output logic             wren
);
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic {IDLE, ACTIVE} state_t;

  // One command; for the active entry, idx tracks the index of the slot on the outputs.
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [31:0]      data;
    logic [1:0]       bpp;
    logic [PAL_W-1:0] palette;
    logic             sprite;
    logic             hflip;
    logic             prio;
    logic             dbl;
  } cmd_t;

  state_t     state;
  cmd_t       act_cmd;
  cmd_t       pend_cmd;
  cmd_t       in_cmd;
  cmd_t       sel_cmd;
  logic       pend_full;
  logic [5:0] slot;
  logic       attr_mem [DEPTH];

  logic       in_dbl;
  logic       accept;
  logic       cont;
  logic       sel_go;
  logic [5:0] sel_slot;
  logic [5:0] npix;
  logic [5:0] total;
  logic [5:0] kidx;
  logic [5:0] kflip;
  logic [5:0] shamt;
  logic [7:0] top;
  logic [7:0] pixel;
  logic [7:0] data_nx;
  logic [3:0] pal4;
  logic       pix_nz;
  logic       attr_rd;
  logic       suppress;
  logic       wren_nx;
  logic       last_nx;

`ifdef LINE_RENDERER_HDOUBLE_EN
  assign in_dbl = cmd_double;
`else
  // Doubling is not built: the port is accepted and ignored.
  logic unused_double;
  assign unused_double = cmd_double;
  assign in_dbl = 1'b0;
`endif

  assign cmd_ready = !pend_full;
  assign busy      = (state == ACTIVE) || pend_full;
  assign accept    = cmd_valid && cmd_ready;
  // The slot on the outputs is the last one of the active command exactly when last_pixel is high.
  assign cont      = (state == ACTIVE) && !last_pixel;

  // Gather the offered command into one record.
  always_comb begin
    in_cmd.idx     = cmd_idx;
    in_cmd.data    = cmd_data;
    in_cmd.bpp     = cmd_bpp;
    in_cmd.palette = cmd_palette;
    in_cmd.sprite  = cmd_sprite;
    in_cmd.hflip   = cmd_hflip;
    in_cmd.prio    = cmd_priority;
    in_cmd.dbl     = in_dbl;
  end

  // Choose the source of the next slot: continue active, hand over pending, or start the new command.
  always_comb begin
    sel_go   = 1'b0;
    sel_cmd  = act_cmd;
    sel_slot = slot + 6'd1;
    if (cont) begin
      sel_go      = 1'b1;
      sel_cmd.idx = act_cmd.idx + 1'b1;
    end else if (pend_full) begin
      sel_go   = 1'b1;
      sel_cmd  = pend_cmd;
      sel_slot = '0;
    end else if (accept) begin
      sel_go   = 1'b1;
      sel_cmd  = in_cmd;
      sel_slot = '0;
    end
  end

  // Pixel extraction, colour formatting and sprite suppression for the next slot.
  always_comb begin
    case (sel_cmd.bpp)
      2'd1:    npix = 6'd16;
      2'd2:    npix = 6'd4;
      default: npix = 6'd8;
    endcase
    total = npix << sel_cmd.dbl;
    kidx  = sel_cmd.dbl ? {1'b0, sel_slot[5:1]} : sel_slot;
    kflip = sel_cmd.hflip ? (npix - 6'd1 - kidx) : kidx;
    case (sel_cmd.bpp)
      2'd1:    shamt = kflip * 6'd2;
      2'd2:    shamt = kflip * 6'd8;
      default: shamt = kflip * 6'd4;
    endcase
    // Pixel k is moved to the top of the word, so it always sits in the MSBs of top.
    top  = 8'((sel_cmd.data << shamt) >> 24);
    pal4 = 4'(sel_cmd.palette);
    case (sel_cmd.bpp)
      2'd2: begin
        pixel   = top;
        data_nx = top;
      end
      2'd1: begin
        pixel   = {6'b0, top[7:6]};
        data_nx = {pal4, 2'b00, top[7:6]};
      end
      default: begin
        pixel   = {4'b0, top[7:4]};
        data_nx = {pal4, top[7:4]};
      end
    endcase
    pix_nz   = |pixel;
    attr_rd  = attr_mem[sel_cmd.idx];
    suppress = sel_cmd.sprite && (!pix_nz || (attr_rd && !sel_cmd.prio));
    wren_nx  = sel_go && !suppress;
    last_nx  = sel_go && (sel_slot == total - 6'd1);
  end

  // Attribute update is issued together with the slot, so the following slot's read already sees it.
  always_ff @(posedge clk) begin
    if (reset_n && wren_nx) begin
      attr_mem[sel_cmd.idx] <= sel_cmd.prio && pix_nz;
    end
  end

  // Control FSM with the registered write-port outputs and the pending slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      act_cmd    <= '0;
      pend_cmd   <= '0;
      pend_full  <= 1'b0;
      slot       <= '0;
      wren       <= 1'b0;
      wridx      <= '1;
      wrdata     <= '0;
      last_pixel <= 1'b0;
    end else begin
      wren       <= wren_nx;
      last_pixel <= last_nx;
      if (sel_go) begin
        state   <= ACTIVE;
        act_cmd <= sel_cmd;
        slot    <= sel_slot;
        wridx   <= sel_cmd.idx;
        wrdata  <= data_nx;
      end else begin
        state <= IDLE;
      end
      if (cont) begin
        if (accept) begin
          pend_cmd  <= in_cmd;
          pend_full <= 1'b1;
        end
      end else if (pend_full) begin
        pend_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_line_renderer.sv
// tb_line_renderer: directed and randomized stimulus for line_renderer against a slot-list reference model.
`timescale 1ns/1ps
module tb_line_renderer;
  localparam int IDX_W = 9;
  localparam int PAL_W = 4;
  localparam int DEPTH = 1 << IDX_W;
`ifdef LINE_RENDERER_HDOUBLE_EN
  localparam bit DOUBLE_ON = 1'b1;
`else
  localparam bit DOUBLE_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [IDX_W-1:0] cmd_idx;
  logic [31:0]      cmd_data;
  logic [1:0]       cmd_bpp;
  logic [PAL_W-1:0] cmd_palette;
  logic             cmd_sprite;
  logic             cmd_hflip;
  logic             cmd_priority;
  logic             cmd_double;
  logic             busy;
  logic             last_pixel;
  logic [IDX_W-1:0] wridx;
  logic [7:0]       wrdata;
  logic             wren;

  always #5 clk = ~clk;

  line_renderer #(.IDX_W(IDX_W), .PAL_W(PAL_W)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_idx(cmd_idx), .cmd_data(cmd_data), .cmd_bpp(cmd_bpp), .cmd_palette(cmd_palette),
    .cmd_sprite(cmd_sprite), .cmd_hflip(cmd_hflip), .cmd_priority(cmd_priority),
    .cmd_double(cmd_double), .busy(busy), .last_pixel(last_pixel),
    .wridx(wridx), .wrdata(wrdata), .wren(wren)
  );

  // Reference model: every accepted command becomes a list of timed slots.
  typedef struct {
    int cyc;
    int idx;
    int pix;
    int dat;
    bit sprite;
    bit prio;
    bit last;
  } slot_t;

  typedef struct {
    int cyc;
    int idx;
    int dat;
  } wr_t;

  slot_t q[$];
  wr_t   wlog[$];
  bit    attr_m [DEPTH];
  int    cyc = 0;
  int    free_cyc = 0;
  int    last_start = -1;
  int    acc_cnt = 0;
  int    last_idx = -1;
  int    errors = 0;
  int    checks = 0;
  bit    ready_exp;
  bit    busy_exp;
  bit    en_exp;
  int    st;
  int    ns;
  slot_t cur;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int expand(input int idx, input logic [31:0] d, input int bpp, input int pal,
                                input bit sp, input bit hf, input bit pr, input bit db, input int start);
    int bb;
    int n;
    int reps;
    bb   = (bpp == 1) ? 2 : (bpp == 2) ? 8 : 4;
    n    = 32 / bb;
    reps = (db && DOUBLE_ON) ? 2 : 1;
    for (int s = 0; s < n * reps; s++) begin
      slot_t e;
      int k;
      int src;
      k        = s / reps;
      src      = hf ? (n - 1 - k) : k;
      e.pix    = int'((d >> (32 - (src + 1) * bb)) & ((32'd1 << bb) - 32'd1));
      e.dat    = (bb == 8) ? e.pix : (((pal & 15) << 4) | e.pix);
      e.idx    = (idx + s) % DEPTH;
      e.cyc    = start + s;
      e.sprite = sp;
      e.prio   = pr;
      e.last   = (s == n * reps - 1);
      q.push_back(e);
    end
    return n * reps;
  endfunction

  // Applies a slot to the attribute model and tells whether it writes.
  function automatic bit realize(input slot_t s);
    bit en;
    en = !(s.sprite && (s.pix == 0 || (attr_m[s.idx] && !s.prio)));
    if (en) attr_m[s.idx] = s.prio && (s.pix != 0);
    return en;
  endfunction

  // Compare process: checks every cycle against the model, then records acceptance.
  always @(negedge clk) begin
    if (!reset_n) begin
      if (q.size() > 0 && q[0].cyc == cyc) void'(realize(q[0]));
      q.delete();
      free_cyc   = 0;
      last_start = -1;
      chk("rst_wren", wren, 0);
      chk("rst_wridx", wridx, DEPTH - 1);
      chk("rst_wrdata", wrdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_last", last_pixel, 0);
      chk("rst_ready", cmd_ready, 1);
    end else begin
      ready_exp = !(last_start > cyc);
      busy_exp  = (q.size() > 0) && (q[0].cyc == cyc);
      chk("cmd_ready", cmd_ready, ready_exp);
      chk("busy", busy, busy_exp);
      if (busy_exp) begin
        cur    = q.pop_front();
        en_exp = realize(cur);
        chk("wren", wren, en_exp);
        chk("wridx", wridx, cur.idx);
        if (en_exp) chk("wrdata", wrdata, cur.dat);
        chk("last_pixel", last_pixel, cur.last);
      end else begin
        chk("idle_wren", wren, 0);
        chk("idle_last", last_pixel, 0);
      end
      if (wren === 1'b1) wlog.push_back('{cyc, int'(wridx), int'(wrdata)});
      if (last_pixel === 1'b1) last_idx = int'(wridx);
      if (cmd_valid && ready_exp) begin
        st = (cyc + 1 > free_cyc) ? cyc + 1 : free_cyc;
        ns = expand(int'(cmd_idx), cmd_data, int'(cmd_bpp), int'(cmd_palette),
                    cmd_sprite, cmd_hflip, cmd_priority, cmd_double, st);
        free_cyc   = st + ns;
        last_start = st;
        acc_cnt++;
      end
    end
    cyc++;
  end

  task automatic send(input int idx, input logic [31:0] d, input int bpp, input int pal,
                      input bit sp, input bit hf, input bit pr, input bit db);
    int n0;
    int t;
    n0 = acc_cnt;
    t  = 0;
    cmd_idx      = IDX_W'(idx);
    cmd_data     = d;
    cmd_bpp      = 2'(bpp);
    cmd_palette  = PAL_W'(pal);
    cmd_sprite   = sp;
    cmd_hflip    = hf;
    cmd_priority = pr;
    cmd_double   = db;
    cmd_valid    = 1'b1;
    while (acc_cnt == n0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    if (acc_cnt == n0) begin
      checks++;
      errors++;
      $display("FAIL send_accept: command not accepted within %0d cycles", t);
    end
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((q.size() != 0 || last_start > cyc) && t < 400) begin
      @(posedge clk);
      t++;
    end
    if (t >= 400) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: model still busy after %0d cycles", t);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_mid(input int bpp, input int idx);
    wlog.delete();
    send(idx, 32'h11223344, bpp, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("t039_wren_now", wren, 0);
    chk("t039_wridx_now", wridx, 9'h1FF);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("t039_write_count", wlog.size(), 3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_valid = 0; cmd_idx = '0; cmd_data = '0; cmd_bpp = '0; cmd_palette = '0;
    cmd_sprite = 0; cmd_hflip = 0; cmd_priority = 0; cmd_double = 0;
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b1;

    // Bring the attribute memory to a known all-zero state with priority-0 tiles.
    for (int i = 0; i < DEPTH / 16; i++) send(i * 16, $urandom, 1, $urandom_range(0, 15), 0, 0, 0, 0);
    wait_idle();

    // 4bpp tile with palette 3.
    wlog.delete(); last_idx = -1;
    send(16, 32'h12345678, 0, 3, 0, 0, 0, 0);
    wait_idle();
    chk("t035_count", wlog.size(), 8);
    if (wlog.size() == 8) begin
      chk("t035_idx0", wlog[0].idx, 9'h010);
      chk("t035_dat0", wlog[0].dat, 8'h31);
      chk("t035_dat3", wlog[3].dat, 8'h34);
      chk("t035_idx7", wlog[7].idx, 9'h017);
      chk("t035_dat7", wlog[7].dat, 8'h38);
    end
    chk("t035_last_idx", last_idx, 9'h017);

    // Flipped 2bpp sprite wrapping past the end of the buffer.
    wlog.delete(); last_idx = -1;
    send(9'h1FC, 32'h0000000F, 1, 0, 1, 1, 0, 0);
    wait_idle();
    chk("t036_count", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("t036_idx0", wlog[0].idx, 9'h1FC);
      chk("t036_dat0", wlog[0].dat, 8'h03);
      chk("t036_idx1", wlog[1].idx, 9'h1FD);
      chk("t036_dat1", wlog[1].dat, 8'h03);
    end
    chk("t036_last_idx", last_idx, 9'h00B);
    chk("t036_busy_after", busy, 0);

    // Second command offered during slot 2 of the first.
    wlog.delete();
    send(64, 32'h11111111, 0, 5, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    send(80, 32'h22222222, 0, 6, 0, 0, 0, 0);
    chk("t037_ready_low", cmd_ready, 0);
    wait_idle();
    chk("t037_count", wlog.size(), 16);
    if (wlog.size() == 16) begin
      chk("t037_idx7", wlog[7].idx, 71);
      chk("t037_idx8", wlog[8].idx, 80);
      chk("t037_dat8", wlog[8].dat, 8'h62);
      chk("t037_gap", wlog[8].cyc - wlog[7].cyc, 1);
    end

    // Priority: high-priority tile blocks a low-priority sprite but not a high-priority one.
    send(0, 32'h11111111, 0, 1, 0, 0, 1, 0);
    wait_idle();
    wlog.delete();
    send(0, 32'h22222222, 0, 1, 1, 0, 0, 0);
    wait_idle();
    chk("t038_blocked", wlog.size(), 0);
    wlog.delete();
    send(0, 32'h22222222, 0, 1, 1, 0, 1, 0);
    wait_idle();
    chk("t038_written", wlog.size(), 8);
    if (wlog.size() == 8) chk("t038_dat0", wlog[0].dat, 8'h12);

    // Doubling request: honoured only when the feature is built.
    wlog.delete(); last_idx = -1;
    send(256, 32'hAABBCCDD, 2, 0, 0, 0, 0, 1);
    wait_idle();
`ifdef LINE_RENDERER_HDOUBLE_EN
    chk("t040_count", wlog.size(), 8);
    if (wlog.size() == 8) begin
      chk("t040_dat0", wlog[0].dat, 8'hAA);
      chk("t040_dat1", wlog[1].dat, 8'hAA);
      chk("t040_dat2", wlog[2].dat, 8'hBB);
      chk("t040_dat7", wlog[7].dat, 8'hDD);
    end
    chk("t040_last_idx", last_idx, 9'h107);
`else
    chk("t040_count", wlog.size(), 4);
    if (wlog.size() == 4) begin
      chk("t040_dat0", wlog[0].dat, 8'hAA);
      chk("t040_dat1", wlog[1].dat, 8'hBB);
      chk("t040_dat3", wlog[3].dat, 8'hDD);
    end
    chk("t040_last_idx", last_idx, 9'h103);
`endif

    // Randomized traffic over a narrow index window so sprites and priorities interact.
    for (int i = 0; i < 150; i++) begin
      int gap;
      send($urandom_range(0, 63), $urandom & $urandom, $urandom_range(0, 3), $urandom_range(0, 15),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      gap = $urandom_range(0, 5);
      if (gap > 3) gap = 0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    wait_idle();

    // Reset in the middle of commands aborts them.
    reset_mid(2, 9'h0F0);
    reset_mid(0, 9'h0F8);
    reset_mid(1, 9'h1FE);

    // Traffic after the aborts must behave normally.
    for (int i = 0; i < 20; i++) begin
      send($urandom_range(0, 511), $urandom, $urandom_range(0, 3), $urandom_range(0, 15),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/line_renderer.md
LINE_RENDERER -- requirements
Module: line_renderer

Interface
REQ-001 Parameter IDX_W, default 9, line-buffer index width; the buffer holds 2^IDX_W entries.
REQ-002 Parameter PAL_W, default 4, palette field width; must be 1..4.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command slot free; transfer occurs when cmd_valid && cmd_ready.
REQ-007 cmd_idx  input  IDX_W  line-buffer index of first pixel.
REQ-008 cmd_data  input  32  packed pixel word; pixel 0 occupies the MSBs.
REQ-009 cmd_bpp  input  2  0=4bpp (8 px), 1=2bpp (16 px), 2=8bpp (4 px), 3=reserved (treated as 4bpp).
REQ-010 cmd_palette  input  PAL_W  palette select.
REQ-011 cmd_sprite / cmd_hflip / cmd_priority / cmd_double  input  1 each  sprite mode, horizontal flip, priority, pixel doubling.
REQ-012 busy  output  1  command active or pending.
REQ-013 last_pixel  output  1  one-cycle pulse with final pixel slot of each command.
REQ-014 wridx / wrdata / wren  output  IDX_W / 8 / 1  line-buffer write port.

Function
REQ-015 Pixel count per command SHALL be N = 32/bpp; pixel k is taken from bits [31-k*bpp -: bpp], or index N-1-k when cmd_hflip=1.
REQ-016 wrdata SHALL be: 8bpp = pixel; 4bpp = {palette zero-extended to 4 bits, pixel}; 2bpp = {palette zero-extended to 4 bits, 2'b00, pixel}.
REQ-017 Latency: the write slot for pixel 0 SHALL appear on the outputs in the cycle after acceptance, one slot per cycle thereafter, no gaps.
REQ-018 The slot index SHALL start at cmd_idx and increment by 1 per slot, wrapping modulo 2^IDX_W.
REQ-019 Two-entry command path: active register plus one pending register; cmd_ready = pending empty.
REQ-020 A command accepted while idle SHALL become active immediately; one accepted while active SHALL go to pending.
REQ-021 On the final slot of the active command, a pending command SHALL become active so its pixel 0 slot follows in the very next cycle.
REQ-022 State: IDLE -> ACTIVE on accept; ACTIVE -> ACTIVE on final slot with pending or simultaneous accept; ACTIVE -> IDLE on final slot otherwise.
REQ-023 A simultaneous accept and final slot with pending empty SHALL load the new command directly as active.
REQ-024 busy SHALL be 1 whenever the state is ACTIVE or pending is full.
REQ-025 Sprite pixels with value 0 SHALL be suppressed (wren=0); slot still consumed; tile pixels are never suppressed for value 0.
REQ-026 Internal attribute memory SHALL hold 2^IDX_W one-bit entries; each performed write stores (cmd_priority && pixel!=0) at its index.
REQ-027 A sprite pixel SHALL be suppressed when its attribute bit is 1 and cmd_priority=0; suppressed writes do not update the attribute bit.
REQ-028 Attribute reads SHALL be write-first: a write in cycle t to index i is visible to a read of i in cycle t+1.
REQ-029 last_pixel SHALL assert in the final slot even if that write is suppressed.

Reset
REQ-030 While reset_n=0: wren=0, wridx=all ones, wrdata=0, busy=0, last_pixel=0, cmd_ready=1; active and pending commands are discarded.
REQ-031 Reset SHALL NOT clear the attribute memory.
REQ-032 Reset asserted mid-command SHALL abort the command with no further writes after deassertion.

Configuration
REQ-033 LINE_RENDERER_HDOUBLE_EN defined: when cmd_double=1, each pixel is written in two consecutive slots at consecutive indices, giving 2N slots, and last_pixel marks slot 2N-1.
REQ-034 LINE_RENDERER_HDOUBLE_EN undefined: the cmd_double port remains present but is ignored and treated as 0; no doubling logic is built.

Verification
REQ-035 4bpp tile: idx=0x010, data=0x12345678, pal=3 -> wridx 0x010..0x017, wrdata 0x31..0x38, last_pixel on 0x017.
REQ-036 Sprite with hflip: 2bpp, idx=0x1FC, data=0x0000000F, pal=0 -> first slot writes 0x03 at 0x1FC, second writes 0x03 at 0x1FD, then 14 suppressed slots with wrap 0x1FF->0x000; busy=0 after slot 16.
REQ-037 Back-to-back: second command offered during the first command's slot 2 -> accepted, cmd_ready=0 until handover, and no idle cycle between slot 7 of the first and slot 0 of the second.
REQ-038 Priority: tile, priority=1, data=0x11111111 at idx 0; then sprite, priority=0, same idx -> all sprite writes suppressed; repeating the sprite with priority=1 -> all 8 written.
REQ-039 Reset pulse during slot 3 of a 8bpp command -> wren=0 and wridx=0x1FF immediately; no writes after release.
REQ-040 With LINE_RENDERER_HDOUBLE_EN: 8bpp, double=1, data=0xAABBCCDD, idx=0 -> 8 slots writing AA,AA,BB,BB,CC,CC,DD,DD; last_pixel on slot 7.
